// File: rtl/pc_seq_if.sv
// Fetch-stage bus between the instruction decoder and the pc_seq program-counter sequencer.
interface pc_seq_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IMM_W  = 10,
  parameter int unsigned CNT_W  = 16
) ();
  logic              stall;
  logic              resume;
  logic [2:0]        bsig;
  logic [2:0]        cond;
  logic [2:0]        flags;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] regsrc;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              taken;
  logic              halted;
  logic              ras_empty;
  logic              ras_err;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output stall, resume, bsig, cond, flags, imm, regsrc,
    input  pc, pc_next, taken, halted, ras_empty, ras_err, taken_cnt
  );

  modport slave (
    input  stall, resume, bsig, cond, flags, imm, regsrc,
    output pc, pc_next, taken, halted, ras_empty, ras_err, taken_cnt
  );
endinterface

// File: rtl/pc_seq.sv
// Registered PC sequencer: branches, circular return-address stack, halt/resume FSM and stall.
// Optional taken-branch counter is built only when PC_SEQ_BRCNT_EN is defined.
module pc_seq #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       IMM_W     = 10,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic      clk,
  input logic      rst_n,
  pc_seq_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q, state_d;
  addr_t           pc_q, pc_d;
  addr_t           pc_next, seq, tgt, top;
  addr_t           ras_q [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d;  // next free slot; top entry sits just below
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            truth, taken, push, pop, push_en;

  assign seq = pc_q + addr_t'(2);
  assign tgt = seq + {{(ADDR_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  assign top = ras_q[ptr_q - PtrW'(1)];

  // flags = {N, V, Z}
  always_comb begin
    truth = 1'b0;
    unique case (bus.cond)
      3'b000: truth = ~bus.flags[0];
      3'b001: truth = bus.flags[0];
      3'b010: truth = ~bus.flags[0] & ~bus.flags[2];
      3'b011: truth = bus.flags[2];
      3'b100: truth = bus.flags[0] | ~bus.flags[2];
      3'b101: truth = bus.flags[2] | bus.flags[0];
      3'b110: truth = bus.flags[1];
      3'b111: truth = 1'b1;
      default: truth = 1'b0;
    endcase
  end

  always_comb begin
    pc_next = seq;
    taken   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    pc_d    = pc_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      StRun: begin
        unique case (bus.bsig)
          3'b001: begin
            if (truth) begin
              pc_next = tgt;
              taken   = 1'b1;
            end
          end
          3'b010: begin
            if (truth) begin
              pc_next = bus.regsrc;
              taken   = 1'b1;
            end
          end
          3'b011: begin
            pc_next = pc_q;
            state_d = StHalt;
          end
          3'b100: begin
            pc_next = tgt;
            taken   = 1'b1;
            push    = 1'b1;
          end
          3'b101: begin
            if (cnt_q != '0) begin
              pc_next = top;
              taken   = 1'b1;
              pop     = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
        pc_d = pc_next;
      end
      StHalt: begin
        pc_next = pc_q;
        if (bus.resume) begin
          pc_d    = seq;
          state_d = StRun;
        end
      end
      default: ;
    endcase

    // A push onto a full stack overwrites the oldest slot, so depth saturates.
    if (push) begin
      ptr_d = ptr_q + PtrW'(1);
      if (cnt_q == (PtrW+1)'(RAS_DEPTH)) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (PtrW+1)'(1);
      end
    end else if (pop) begin
      ptr_d = ptr_q - PtrW'(1);
      cnt_d = cnt_q - (PtrW+1)'(1);
    end

    if (bus.stall) begin
      pc_d    = pc_q;
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
    end
  end

  assign push_en = push & ~bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= StRun;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (push_en) begin
        ras_q[ptr_q] <= seq;
      end
    end
  end

`ifdef PC_SEQ_BRCNT_EN
  logic [CNT_W-1:0] brcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brcnt_q <= '0;
    end else if (taken && !bus.stall) begin
      brcnt_q <= brcnt_q + CNT_W'(1);
    end
  end

  assign bus.taken_cnt = brcnt_q;
`else
  assign bus.taken_cnt = {CNT_W{1'b0}};
`endif

  assign bus.pc        = pc_q;
  assign bus.pc_next   = pc_next;
  assign bus.taken     = taken;
  assign bus.halted    = (state_q == StHalt);
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_err   = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: branches, return stack, halt/resume, stall and async reset.
module tb_pc_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] exp_cnt = '0;

  pc_seq_if #(.ADDR_W(16), .IMM_W(10), .CNT_W(16)) bus ();

  pc_seq #(
    .ADDR_W(16), .IMM_W(10), .RAS_DEPTH(4), .CNT_W(16), .RESET_PC(16'h0100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] want_cnt();
`ifdef PC_SEQ_BRCNT_EN
    return exp_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] b, input logic [2:0] c, input logic [2:0] f,
                       input logic [9:0] im, input logic [15:0] rs);
    bus.bsig   = b;
    bus.cond   = c;
    bus.flags  = f;
    bus.imm    = im;
    bus.regsrc = rs;
    bus.stall  = 1'b0;
    bus.resume = 1'b0;
  endtask

  task automatic test_reset();
    drive(3'b000, 3'b000, 3'b000, 10'h000, 16'h0000);
    #12;
    tests++; if (bus.pc !== 16'h0100) begin fails++; $display("FAIL rst_pc got=%h exp=0100", bus.pc); end
    tests++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL rst_halted got=%b exp=0", bus.halted); end
    tests++; if (bus.ras_empty !== 1'b1) begin fails++; $display("FAIL rst_empty got=%b exp=1", bus.ras_empty); end
    tests++; if (bus.ras_err !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", bus.ras_err); end
    tests++; if (bus.taken_cnt !== 16'h0) begin fails++; $display("FAIL rst_cnt got=%h exp=0", bus.taken_cnt); end
    rst_n = 1'b1;
    #1;
    tests++; if (bus.pc !== 16'h0100) begin fails++; $display("FAIL seq0 got=%h exp=0100", bus.pc); end
    tick();
    tests++; if (bus.pc !== 16'h0102) begin fails++; $display("FAIL seq1 got=%h exp=0102", bus.pc); end
    tick();
    tests++; if (bus.pc !== 16'h0104) begin fails++; $display("FAIL seq2 got=%h exp=0104", bus.pc); end
    tick();
    tests++; if (bus.pc !== 16'h0106) begin fails++; $display("FAIL seq3 got=%h exp=0106", bus.pc); end
    tests++; if (bus.halted !== 1'b0 || bus.ras_empty !== 1'b1) begin
      fails++; $display("FAIL seq_status halted=%b empty=%b exp=0/1", bus.halted, bus.ras_empty);
    end
  endtask

  task automatic test_branch();
    drive(3'b010, 3'b111, 3'b000, 10'h000, 16'h0010);
    tick(); exp_cnt++;
    tests++; if (bus.pc !== 16'h0010) begin fails++; $display("FAIL br_abs got=%h exp=0010", bus.pc); end
    // cond 100 = Z|~N; N=1 Z=0 -> false
    drive(3'b001, 3'b100, 3'b100, 10'h3FC, 16'h0000);
    #1;
    tests++; if (bus.taken !== 1'b0) begin fails++; $display("FAIL b_nt_taken got=%b exp=0", bus.taken); end
    tests++; if (bus.pc_next !== 16'h0012) begin fails++; $display("FAIL b_nt_next got=%h exp=0012", bus.pc_next); end
    tick();
    tests++; if (bus.pc !== 16'h0012) begin fails++; $display("FAIL b_nt_pc got=%h exp=0012", bus.pc); end
    drive(3'b010, 3'b111, 3'b000, 10'h000, 16'h0010);
    tick(); exp_cnt++;
    drive(3'b001, 3'b100, 3'b101, 10'h3FC, 16'h0000);
    #1;
    tests++; if (bus.taken !== 1'b1) begin fails++; $display("FAIL b_t_taken got=%b exp=1", bus.taken); end
    tests++; if (bus.pc_next !== 16'h000E) begin fails++; $display("FAIL b_t_next got=%h exp=000e", bus.pc_next); end
    tick(); exp_cnt++;
    tests++; if (bus.pc !== 16'h000E) begin fails++; $display("FAIL b_t_pc got=%h exp=000e", bus.pc); end
    // cond 010 = ~Z&~N, true with all flags clear: 0x0010 + 0x10
    drive(3'b001, 3'b010, 3'b000, 10'h010, 16'h0000);
    tick(); exp_cnt++;
    tests++; if (bus.pc !== 16'h0020) begin fails++; $display("FAIL b_fwd_pc got=%h exp=0020", bus.pc); end
    tests++; if (bus.taken_cnt !== want_cnt()) begin
      fails++; $display("FAIL br_cnt got=%h exp=%h", bus.taken_cnt, want_cnt());
    end
  endtask

  task automatic test_call_ret();
    drive(3'b100, 3'b000, 3'b000, 10'h040, 16'h0000);
    #1;
    tests++; if (bus.taken !== 1'b1 || bus.pc_next !== 16'h0062) begin
      fails++; $display("FAIL call_comb taken=%b next=%h exp=1/0062", bus.taken, bus.pc_next);
    end
    tick(); exp_cnt++;
    tests++; if (bus.pc !== 16'h0062 || bus.ras_empty !== 1'b0) begin
      fails++; $display("FAIL call_pc pc=%h empty=%b exp=0062/0", bus.pc, bus.ras_empty);
    end
    drive(3'b101, 3'b000, 3'b000, 10'h000, 16'h0000);
    #1;
    tests++; if (bus.taken !== 1'b1 || bus.pc_next !== 16'h0022) begin
      fails++; $display("FAIL ret_comb taken=%b next=%h exp=1/0022", bus.taken, bus.pc_next);
    end
    tick(); exp_cnt++;
    tests++; if (bus.pc !== 16'h0022 || bus.ras_empty !== 1'b1 || bus.ras_err !== 1'b0) begin
      fails++; $display("FAIL ret_pc pc=%h empty=%b err=%b exp=0022/1/0", bus.pc, bus.ras_empty,
                        bus.ras_err);
    end
    #1;
    tests++; if (bus.taken !== 1'b0 || bus.pc_next !== 16'h0024) begin
      fails++; $display("FAIL uflow_comb taken=%b next=%h exp=0/0024", bus.taken, bus.pc_next);
    end
    tick();
    tests++; if (bus.pc !== 16'h0024 || bus.ras_err !== 1'b1) begin
      fails++; $display("FAIL uflow_pc pc=%h err=%b exp=0024/1", bus.pc, bus.ras_err);
    end
    tests++; if (bus.taken_cnt !== want_cnt()) begin
      fails++; $display("FAIL cr_cnt got=%h exp=%h", bus.taken_cnt, want_cnt());
    end
  endtask

  task automatic test_async_reset();
    drive(3'b100, 3'b000, 3'b000, 10'h040, 16'h0000);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.pc !== 16'h0100) begin fails++; $display("FAIL arst_pc got=%h exp=0100", bus.pc); end
    tests++; if (bus.ras_empty !== 1'b1 || bus.ras_err !== 1'b0 || bus.halted !== 1'b0) begin
      fails++; $display("FAIL arst_state empty=%b err=%b halted=%b exp=1/0/0", bus.ras_empty,
                        bus.ras_err, bus.halted);
    end
    tests++; if (bus.taken_cnt !== 16'h0) begin fails++; $display("FAIL arst_cnt got=%h exp=0", bus.taken_cnt); end
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ras_overflow();
    logic [15:0] call_pc [5];
    logic [15:0] ret_pc  [5];
    call_pc = '{16'h0112, 16'h0124, 16'h0136, 16'h0148, 16'h015A};
    ret_pc  = '{16'h014A, 16'h0138, 16'h0126, 16'h0114, 16'h0116};
    drive(3'b100, 3'b000, 3'b000, 10'h010, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick(); exp_cnt++;
      tests++; if (bus.pc !== call_pc[i]) begin
        fails++; $display("FAIL ovf_call%0d got=%h exp=%h", i, bus.pc, call_pc[i]);
      end
      if (i == 3) begin
        tests++; if (bus.ras_err !== 1'b0) begin fails++; $display("FAIL ovf_full_err got=%b exp=0", bus.ras_err); end
      end
    end
    tests++; if (bus.ras_err !== 1'b1) begin fails++; $display("FAIL ovf_err got=%b exp=1", bus.ras_err); end
    drive(3'b101, 3'b000, 3'b000, 10'h000, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) exp_cnt++;
      tests++; if (bus.pc !== ret_pc[i]) begin
        fails++; $display("FAIL ovf_ret%0d got=%h exp=%h", i, bus.pc, ret_pc[i]);
      end
    end
    tests++; if (bus.ras_empty !== 1'b1) begin fails++; $display("FAIL ovf_empty got=%b exp=1", bus.ras_empty); end
    tests++; if (bus.taken_cnt !== want_cnt()) begin
      fails++; $display("FAIL ovf_cnt got=%h exp=%h", bus.taken_cnt, want_cnt());
    end
  endtask

  task automatic test_halt();
    logic [15:0] cnt_snap;
    drive(3'b010, 3'b111, 3'b000, 10'h000, 16'h0030);
    tick(); exp_cnt++;
    // hlt and resume together in RUN: hlt wins
    drive(3'b011, 3'b111, 3'b000, 10'h000, 16'h0000);
    bus.resume = 1'b1;
    #1;
    tests++; if (bus.taken !== 1'b0 || bus.pc_next !== 16'h0030) begin
      fails++; $display("FAIL hlt_comb taken=%b next=%h exp=0/0030", bus.taken, bus.pc_next);
    end
    tick();
    tests++; if (bus.pc !== 16'h0030 || bus.halted !== 1'b1) begin
      fails++; $display("FAIL hlt_enter pc=%h halted=%b exp=0030/1", bus.pc, bus.halted);
    end
    for (int i = 0; i < 10; i++) begin
      drive(3'($urandom_range(0, 7)), 3'b111, 3'b000, 10'h020, 16'hABCD);
      #1;
      tests++; if (bus.taken !== 1'b0 || bus.pc_next !== 16'h0030) begin
        fails++; $display("FAIL hlt_comb%0d taken=%b next=%h exp=0/0030", i, bus.taken, bus.pc_next);
      end
      tick();
      tests++; if (bus.pc !== 16'h0030 || bus.halted !== 1'b1) begin
        fails++; $display("FAIL hlt_hold%0d pc=%h halted=%b exp=0030/1", i, bus.pc, bus.halted);
      end
    end
    drive(3'b000, 3'b000, 3'b000, 10'h000, 16'h0000);
    bus.stall  = 1'b1;
    bus.resume = 1'b1;
    tick();
    tests++; if (bus.pc !== 16'h0030 || bus.halted !== 1'b1) begin
      fails++; $display("FAIL hlt_stall pc=%h halted=%b exp=0030/1", bus.pc, bus.halted);
    end
    bus.stall = 1'b0;
    tick();
    tests++; if (bus.pc !== 16'h0032 || bus.halted !== 1'b0) begin
      fails++; $display("FAIL resume pc=%h halted=%b exp=0032/0", bus.pc, bus.halted);
    end
    drive(3'b001, 3'b111, 3'b000, 10'h020, 16'h0000);
    bus.stall = 1'b1;
    cnt_snap  = want_cnt();
    #1;
    tests++; if (bus.taken !== 1'b1 || bus.pc_next !== 16'h0054) begin
      fails++; $display("FAIL stall_comb taken=%b next=%h exp=1/0054", bus.taken, bus.pc_next);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.pc !== 16'h0032 || bus.taken_cnt !== cnt_snap) begin
        fails++; $display("FAIL stall%0d pc=%h cnt=%h exp=0032/%h", i, bus.pc, bus.taken_cnt, cnt_snap);
      end
    end
    bus.stall = 1'b0;
    tick(); exp_cnt++;
    tests++; if (bus.pc !== 16'h0054) begin fails++; $display("FAIL unstall got=%h exp=0054", bus.pc); end
    tests++; if (bus.taken_cnt !== want_cnt()) begin
      fails++; $display("FAIL hlt_cnt got=%h exp=%h", bus.taken_cnt, want_cnt());
    end
  endtask

  task automatic test_back_to_back();
    drive(3'b000, 3'b000, 3'b000, 10'h000, 16'h0000);
    bus.resume = 1'b1;
    tick();
    tests++; if (bus.pc !== 16'h0056 || bus.halted !== 1'b0) begin
      fails++; $display("FAIL run_resume pc=%h halted=%b exp=0056/0", bus.pc, bus.halted);
    end
    drive(3'b010, 3'b110, 3'b000, 10'h000, 16'h1234);
    tick();
    tests++; if (bus.pc !== 16'h0058) begin fails++; $display("FAIL br_v0 got=%h exp=0058", bus.pc); end
    drive(3'b010, 3'b110, 3'b010, 10'h000, 16'h1234);
    tick(); exp_cnt++;
    tests++; if (bus.pc !== 16'h1234) begin fails++; $display("FAIL br_v1 got=%h exp=1234", bus.pc); end
    drive(3'b111, 3'b111, 3'b000, 10'h020, 16'h5555);
    #1;
    tests++; if (bus.taken !== 1'b0) begin fails++; $display("FAIL bsig111_taken got=%b exp=0", bus.taken); end
    tick();
    tests++; if (bus.pc !== 16'h1236) begin fails++; $display("FAIL bsig111 got=%h exp=1236", bus.pc); end
    drive(3'b001, 3'b011, 3'b100, 10'h002, 16'h0000);
    tick(); exp_cnt++;
    tests++; if (bus.pc !== 16'h123A) begin fails++; $display("FAIL b_n got=%h exp=123a", bus.pc); end
    drive(3'b001, 3'b101, 3'b000, 10'h002, 16'h0000);
    tick();
    tests++; if (bus.pc !== 16'h123C) begin fails++; $display("FAIL b_nz got=%h exp=123c", bus.pc); end
    drive(3'b001, 3'b000, 3'b000, 10'h3FE, 16'h0000);
    tick(); exp_cnt++;
    tests++; if (bus.pc !== 16'h123C) begin fails++; $display("FAIL b_back got=%h exp=123c", bus.pc); end
    tests++; if (bus.taken_cnt !== want_cnt()) begin
      fails++; $display("FAIL b2b_cnt got=%h exp=%h", bus.taken_cnt, want_cnt());
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_async_reset();
    test_ras_overflow();
    test_halt();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
